// File: rtl/button_event_arbiter.sv
// button_event_arbiter
//
// Conditions N_BTN raw push buttons (two-flop synchroniser, debounce,
// release detect), latches each release as a pending request and hands the
// requests one at a time to the downstream consumer through a round-robin
// arbiter and a valid/ready event port.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset, clears all state
//   btn_in     raw button levels (asynchronous, 1 = pressed)
//   evt_valid  an event is offered
//   evt_id     index of the offered button, stable while evt_valid is high
//   evt_ready  consumer accepts when high together with evt_valid
//   pending    pending-request flag per button
//   overflow   one-cycle pulse when a release merges into a pending request
//
// Arbiter states
//   state | meaning
//   IDLE  | no event offered; searching pending flags round-robin
//   OFFER | evt_id offered, held until the handshake completes

module button_event_arbiter #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         btn_in,
    output logic                     evt_valid,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    input  logic                     evt_ready,
    output logic [N_BTN-1:0]         pending,
    output logic                     overflow
);

    localparam int ID_W  = $clog2(N_BTN);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t             state, state_d;
    logic [ID_W-1:0]    evt_id_d;
    logic [ID_W-1:0]    last_grant, last_grant_d;

    logic [N_BTN-1:0]   s1, s2, db, db_d;
    logic [CNT_W-1:0]   cnt [N_BTN];
    logic [N_BTN-1:0]   rel, consume, pending_d;
    logic               overflow_d;
    logic               found;
    logic [ID_W-1:0]    pick, idx;

    // Synchroniser and per-button debounce
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_d <= '0;
            for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
        end else begin
            s1   <= btn_in;
            s2   <= s1;
            db_d <= db;
            for (int i = 0; i < N_BTN; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rel = db_d & ~db;

    // A release always leaves the flag set: it either creates the request,
    // merges into an existing one (overflow), or re-arms the flag being
    // consumed this cycle so the new release is not lost.
    always_comb begin
        consume    = '0;
        pending_d  = pending;
        overflow_d = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            consume[i] = evt_valid & evt_ready & (evt_id == ID_W'(i));
            if (rel[i]) begin
                pending_d[i] = 1'b1;
                if (pending[i] && !consume[i]) overflow_d = 1'b1;
            end else if (consume[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= pending_d;
            overflow <= overflow_d;
        end
    end

    // Round-robin search starting just after the last granted index
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int off = 1; off <= N_BTN; off++) begin
            idx = ID_W'((int'(last_grant) + off) % N_BTN);
            if (!found && pending[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d      = state;
        evt_id_d     = evt_id;
        last_grant_d = last_grant;
        case (state)
            IDLE: begin
                if (found) begin
                    evt_id_d = pick;
                    state_d  = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    last_grant_d = evt_id;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            evt_id     <= '0;
            last_grant <= ID_W'(N_BTN - 1);
        end else begin
            state      <= state_d;
            evt_id     <= evt_id_d;
            last_grant <= last_grant_d;
        end
    end

    assign evt_valid = (state == OFFER);

endmodule

// File: tb/tb_button_event_arbiter.sv
module tb_button_event_arbiter;

    localparam int N_BTN = 4;
    localparam int D     = 4;

    logic             clk;
    logic             rst_n;
    logic [N_BTN-1:0] btn_in;
    logic             evt_valid;
    logic [1:0]       evt_id;
    logic             evt_ready;
    logic [N_BTN-1:0] pending;
    logic             overflow;

    int checks = 0;
    int errors = 0;
    int ev_cnt;
    int ev_ids [16];

    button_event_arbiter #(.N_BTN(N_BTN), .DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Press the masked buttons, hold them long enough to debounce, then
    // release at a negedge (the release is seen before the next rising edge).
    task automatic press_release(input logic [N_BTN-1:0] mask);
        btn_in = btn_in | mask;
        step(10);
        btn_in = btn_in & ~mask;
    endtask

    // With evt_ready held high, every valid cycle is one accepted event.
    task automatic collect(input int cycles);
        ev_cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            if (evt_valid === 1'b1) begin
                if (ev_cnt < 16) ev_ids[ev_cnt] = int'(evt_id);
                ev_cnt++;
            end
            step(1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_in    = '0;
        evt_ready = 1'b0;

        // Reset state
        step(2);
        check("rst_valid",    32'(evt_valid), 32'h0);
        check("rst_id",       32'(evt_id),    32'h0);
        check("rst_pending",  32'(pending),   32'h0);
        check("rst_overflow", 32'(overflow),  32'h0);
        rst_n = 1'b1;
        step(2);

        // Single release on button 2, ready already high
        evt_ready = 1'b1;
        btn_in[2] = 1'b1;
        step(10);
        check("press_no_event",   32'({evt_valid, pending}), 32'h0);
        btn_in[2] = 1'b0;
        step(6);
        check("single_pend_early", 32'(pending), 32'h0);
        step(1);
        check("single_pend_set",  32'(pending),   32'h4);
        check("single_valid_lo",  32'(evt_valid), 32'h0);
        step(1);
        check("single_valid_hi",  32'(evt_valid), 32'h1);
        check("single_id",        32'(evt_id),    32'h2);
        step(1);
        check("single_valid_drop", 32'(evt_valid), 32'h0);
        check("single_pend_clr",   32'(pending),   32'h0);
        collect(10);
        check("single_no_more", 32'(ev_cnt), 32'h0);

        // Glitch rejection: 3-cycle pulses on button 0
        repeat (3) begin
            btn_in[0] = 1'b1;
            step(3);
            btn_in[0] = 1'b0;
            step(3);
        end
        collect(15);
        check("glitch_no_event", 32'(ev_cnt),  32'h0);
        check("glitch_pending",  32'(pending), 32'h0);

        // Round-robin from reset: releases on 3, 1, 0 together
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        evt_ready = 1'b0;
        press_release(4'b1011);
        step(7);
        check("rr_pending", 32'(pending), 32'hb);
        step(1);
        check("rr_first_offer", 32'({evt_valid, evt_id}), 32'h4);
        evt_ready = 1'b1;
        collect(12);
        check("rr_count", 32'(ev_cnt),    32'h3);
        check("rr_ev0",   32'(ev_ids[0]), 32'h0);
        check("rr_ev1",   32'(ev_ids[1]), 32'h1);
        check("rr_ev2",   32'(ev_ids[2]), 32'h3);
        check("rr_pend_clr", 32'(pending), 32'h0);

        // After grant 3, search wraps to 0 before 2
        press_release(4'b0101);
        collect(20);
        check("wrap_count", 32'(ev_cnt),    32'h2);
        check("wrap_ev0",   32'(ev_ids[0]), 32'h0);
        check("wrap_ev1",   32'(ev_ids[1]), 32'h2);

        // Backpressure: offer held 20 cycles
        evt_ready = 1'b0;
        press_release(4'b0010);
        step(8);
        check("bp_offer", 32'({evt_valid, evt_id}), 32'h5);
        for (int c = 0; c < 20; c++) begin
            step(1);
            check("bp_hold", 32'({evt_valid, evt_id}), 32'h5);
        end
        evt_ready = 1'b1;
        step(1);
        check("bp_accept_valid", 32'(evt_valid), 32'h0);
        check("bp_accept_pend",  32'(pending),   32'h0);

        // Overflow: button 2 offered, button 1 pending and released again
        evt_ready = 1'b0;
        press_release(4'b0100);
        step(8);
        check("ovf_offer2", 32'({evt_valid, evt_id}), 32'h6);
        press_release(4'b0010);
        step(7);
        check("ovf_pending", 32'(pending),  32'h6);
        check("ovf_quiet",   32'(overflow), 32'h0);
        press_release(4'b0010);
        step(6);
        check("ovf_before", 32'(overflow), 32'h0);
        step(1);
        check("ovf_pulse",  32'(overflow), 32'h1);
        check("ovf_pend_kept", 32'(pending), 32'h6);
        step(1);
        check("ovf_after",  32'(overflow), 32'h0);
        evt_ready = 1'b1;
        collect(15);
        check("ovf_count", 32'(ev_cnt),    32'h2);
        check("ovf_ev0",   32'(ev_ids[0]), 32'h2);
        check("ovf_ev1",   32'(ev_ids[1]), 32'h1);

        // Release on button 1 on the very cycle its event is accepted
        evt_ready = 1'b0;
        press_release(4'b0010);
        step(8);
        check("sim_offer", 32'({evt_valid, evt_id}), 32'h5);
        press_release(4'b0010);
        step(6);
        evt_ready = 1'b1;
        step(1);
        check("sim_valid_drop", 32'(evt_valid), 32'h0);
        check("sim_pend_kept",  32'(pending),   32'h2);
        check("sim_no_ovf",     32'(overflow),  32'h0);
        step(1);
        check("sim_reoffer", 32'({evt_valid, evt_id}), 32'h5);
        step(1);
        check("sim_done", 32'({evt_valid, pending}), 32'h0);

        // Asynchronous reset in the middle of an offer
        evt_ready = 1'b0;
        press_release(4'b1100);
        step(8);
        check("ar_offer",   32'({evt_valid, evt_id}), 32'h6);
        check("ar_pending", 32'(pending), 32'hc);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid",    32'(evt_valid), 32'h0);
        check("ar_pend_clr", 32'(pending),   32'h0);
        check("ar_ovf",      32'(overflow),  32'h0);
        step(2);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        collect(15);
        check("ar_no_event", 32'(ev_cnt),  32'h0);
        check("ar_pend_idle", 32'(pending), 32'h0);
        evt_ready = 1'b0;
        press_release(4'b0110);
        step(8);
        check("ar_fresh_offer", 32'({evt_valid, evt_id}), 32'h5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
